// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage: opcodes, FSM states, widths.
package alu_pkg;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int RA_W     = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_RSH = 3'd1,
    OP_LSH = 3'd2,
    OP_NOT = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_TMP = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WB       = 2'd3
  } seq_state_e;
endpackage

// File: rtl/alu_regfile.sv
// 4x8 general register file: one write port (writeback beats external write),
// combinational reads for operand A, operand B/TMP load and debug.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_en,
  input  logic [RA_W-1:0]   i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_wr_en,
  input  logic [RA_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [RA_W-1:0]   i_a_addr,
  output logic [DATA_W-1:0] o_a_data,
  input  logic [RA_W-1:0]   i_b_addr,
  output logic [DATA_W-1:0] o_b_data,
  input  logic [RA_W-1:0]   i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_wb_en && i_wb_addr == RA_W'(i))
          r_regs[i] <= i_wb_data;
        else if (i_wr_en && i_wr_addr == RA_W'(i))
          r_regs[i] <= i_wr_data;
      end
    end
  end

  assign o_a_data   = r_regs[i_a_addr];
  assign o_b_data   = r_regs[i_b_addr];
  assign o_dbg_data = r_regs[i_dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Four-phase sequencer around an external combinational ALU:
// IDLE (accept) -> LOAD_TMP -> EXEC (capture ACC/flags) -> WB (register write).
module alu_sequencer #(
  parameter bit USE_CARRY = 1'b1,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_ra,
  input  logic [1:0]        req_rb,
  input  logic              clf,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_c_out,
  input  logic              alu_a_larger,
  input  logic              alu_equal,
  input  logic              alu_zero,
  output logic              flag_c,
  output logic              flag_a,
  output logic              flag_e,
  output logic              flag_z
);
  import alu_pkg::*;

  seq_state_e        r_state, w_next;
  alu_op_e           r_op;
  logic [1:0]        r_ra, r_rb;
  logic [DATA_W-1:0] r_tmp, r_acc;
  logic              r_flag_c, r_flag_a, r_flag_e, r_flag_z;
  logic              r_done;
  logic              w_accept, w_wb_en;
  logic [DATA_W-1:0] w_ra_data, w_rb_data;

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    w_accept  = 1'b0;
    w_wb_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = ST_LOAD_TMP;
        end
      end
      ST_LOAD_TMP: w_next = ST_EXEC;
      ST_EXEC:     w_next = ST_WB;
      ST_WB: begin
        w_wb_en = (r_op != OP_CMP);
        w_next  = ST_IDLE;
      end
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_ADD;
      r_ra    <= '0;
      r_rb    <= '0;
      r_tmp   <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // done rises with the register already written, in the cycle after WB
      r_done  <= (r_state == ST_WB);
      if (w_accept) begin
        r_op <= alu_op_e'(req_op);
        r_ra <= req_ra;
        r_rb <= req_rb;
      end
      if (r_state == ST_LOAD_TMP) r_tmp <= w_rb_data;
      if (r_state == ST_EXEC)     r_acc <= alu_c;
    end
  end

  // EXEC overwrites every flag, so clf racing an accept needs no special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_flag_c, r_flag_a, r_flag_e, r_flag_z} <= 4'b0000;
    end else if (r_state == ST_EXEC) begin
      {r_flag_c, r_flag_a, r_flag_e, r_flag_z} <= {alu_c_out, alu_a_larger, alu_equal, alu_zero};
    end else if (r_state == ST_IDLE && clf) begin
      {r_flag_c, r_flag_a, r_flag_e, r_flag_z} <= 4'b0000;
    end
  end

  alu_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wb_en    (w_wb_en),
    .i_wb_addr  (r_rb),
    .i_wb_data  (r_acc),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_a_addr   (r_ra),
    .o_a_data   (w_ra_data),
    .i_b_addr   (r_rb),
    .o_b_data   (w_rb_data),
    .i_dbg_addr (rd_addr),
    .o_dbg_data (rd_data)
  );

  assign alu_a    = w_ra_data;
  assign alu_b    = r_tmp;
  assign alu_op   = r_op;
  assign alu_c_in = USE_CARRY ? r_flag_c : 1'b0;
  assign done     = r_done;
  assign flag_c   = r_flag_c;
  assign flag_a   = r_flag_a;
  assign flag_e   = r_flag_e;
  assign flag_z   = r_flag_z;
endmodule
